// File: rtl/arb_pkg.sv
// ----------------------------------------------------------------------------
// arb_pkg
//   Shared types and helpers for the bus grant controller family.
//   - arb_state_e : grant controller FSM states (IDLE, OWN, GAP)
//   - arb_vec_t   : widest request/grant vector any instance may use
//   - rotl1       : rotate an n-bit one-hot left by one position (wraps)
//   - is_onehot   : nonzero with exactly one bit set
//   - onehot2idx  : bit index of a one-hot vector (0 for an all-zero vector)
//   - hold_w      : tenure counter width for a given MAX_HOLD (at least 1)
//   Callers zero-extend their N-bit vectors to arb_vec_t and size-cast the
//   results back, so one set of helpers serves every N up to ARB_MAX_N.
// ----------------------------------------------------------------------------
package arb_pkg;

  localparam int unsigned ARB_MAX_N = 64;

  typedef logic [ARB_MAX_N-1:0] arb_vec_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

  // Bits at or above n are expected to be zero on entry and are cleared on exit.
  function automatic arb_vec_t rotl1(input arb_vec_t v, input int unsigned n);
    arb_vec_t mask_v;
    // For n == ARB_MAX_N the shift overflows to zero and the subtract yields all ones.
    mask_v = (arb_vec_t'(1'b1) << n) - arb_vec_t'(1'b1);
    return ((v << 1) | (v >> (n - 32'd1))) & mask_v;
  endfunction

  function automatic logic is_onehot(input arb_vec_t v);
    return (v != '0) && ((v & (v - arb_vec_t'(1'b1))) == '0);
  endfunction

  // OR of the indices of set bits: exact for one-hot, 0 for zero.
  function automatic int unsigned onehot2idx(input arb_vec_t v);
    int unsigned idx;
    idx = 32'd0;
    for (int unsigned i = 0; i < ARB_MAX_N; i++) begin
      if (((v >> i) & arb_vec_t'(1'b1)) != '0) begin
        idx = idx | i;
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  function automatic int hold_w(input int max_hold);
    int w;
    w = $clog2(max_hold + 32'sd1);
    if (w < 32'sd1) begin
      w = 32'sd1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/arb_onehot_enc.sv
// ----------------------------------------------------------------------------
// arb_onehot_enc
//   Combinational one-hot to binary index encoder.
//   Ports:
//     onehot  in   N     one-hot (or zero) vector
//     idx     out  ID_W  index of the set bit; 0 when onehot is zero
// ----------------------------------------------------------------------------
module arb_onehot_enc
  import arb_pkg::*;
#(
  parameter int N    = 8,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    onehot,
  output logic [ID_W-1:0] idx
);

  assign idx = ID_W'(onehot2idx(arb_vec_t'(onehot)));

endmodule

// File: rtl/arb_grant_ctrl.sv
// ----------------------------------------------------------------------------
// arb_grant_ctrl
//   Sequential grant controller wrapped around the ppa parallel-prefix arbiter.
//   Drives the ppa priority pointer, captures a legal ppa grant onto the bus,
//   holds it for the owning master up to MAX_HOLD cycles, inserts a one-cycle
//   turnaround, and rotates priority round-robin on every capture.
//   Ports:
//     i_bus_clk    in   1     clock, rising edge
//     i_bus_rstn   in   1     asynchronous active-low reset
//     i_req        in   N     master requests (same vector the ppa sees)
//     i_ppa_grant  in   N     ppa grant, expected one-hot or zero
//     i_ppa_ag     in   1     ppa any-grant
//     o_prior      out  N     one-hot priority to ppa, straight from a register
//     o_grant      out  N     registered bus grant
//     o_grant_vld  out  1     registered |o_grant
//     o_grant_id   out  ID_W  registered index of o_grant (0 when none)
//     o_err        out  1     sticky illegal-grant flag
// ----------------------------------------------------------------------------
module arb_grant_ctrl
  import arb_pkg::*;
#(
  parameter int             N         = 8,
  parameter int             MAX_HOLD  = 16,
  parameter logic [N-1:0]   PRIOR_RST = {1'b1, {(N-1){1'b0}}},
  parameter int             ID_W      = $clog2(N)
) (
  input  logic            i_bus_clk,
  input  logic            i_bus_rstn,
  input  logic [N-1:0]    i_req,
  input  logic [N-1:0]    i_ppa_grant,
  input  logic            i_ppa_ag,
  output logic [N-1:0]    o_prior,
  output logic [N-1:0]    o_grant,
  output logic            o_grant_vld,
  output logic [ID_W-1:0] o_grant_id,
  output logic            o_err
);

  localparam int              HOLD_W   = hold_w(MAX_HOLD);
  localparam logic [HOLD_W-1:0] CNT_SAT  = '1;
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] CNT_ONE  = HOLD_W'(1'b1);

  arb_state_e        state_r;
  logic [N-1:0]      grant_r;
  logic [N-1:0]      prior_r;
  logic [HOLD_W-1:0] cnt_r;
  logic              vld_r;
  logic [ID_W-1:0]   id_r;
  logic              err_r;

  arb_state_e        nxt_state_s;
  logic [N-1:0]      nxt_grant_s;
  logic [N-1:0]      nxt_prior_s;
  logic [HOLD_W-1:0] nxt_cnt_s;
  logic [ID_W-1:0]   nxt_id_s;
  logic              legal_s;
  logic              illegal_s;
  logic              owner_req_s;
  logic              limit_ok_s;
  logic              keep_s;

  assign legal_s     = i_ppa_ag & is_onehot(arb_vec_t'(i_ppa_grant));
  assign illegal_s   = i_ppa_ag & ~legal_s;
  assign owner_req_s = |(i_req & grant_r);
  // MAX_HOLD == 0 means tenure is bounded only by the owner's request.
  assign limit_ok_s  = (MAX_HOLD == 32'sd0) ? 1'b1 : (cnt_r < HOLD_LIM);
  assign keep_s      = owner_req_s & limit_ok_s;

  // Index of the next-state grant so id/vld register alongside o_grant.
  arb_onehot_enc #(
    .N    (N),
    .ID_W (ID_W)
  ) u_enc (
    .onehot (nxt_grant_s),
    .idx    (nxt_id_s)
  );

  // Next-state, next-grant, tenure count and priority decision.
  always_comb begin
    nxt_state_s = state_r;
    nxt_grant_s = grant_r;
    nxt_cnt_s   = cnt_r;
    nxt_prior_s = prior_r;
    case (state_r)
      // GAP makes the same capture decision as IDLE; it only exists so a
      // release is always followed by exactly one grant-free cycle.
      ST_IDLE, ST_GAP: begin
        if (legal_s) begin
          nxt_state_s = ST_OWN;
          nxt_grant_s = i_ppa_grant;
          nxt_cnt_s   = CNT_ONE;
          // Owner becomes lowest priority for the following arbitration.
          nxt_prior_s = N'(rotl1(arb_vec_t'(i_ppa_grant), N));
        end else begin
          nxt_state_s = ST_IDLE;
          nxt_grant_s = '0;
          nxt_cnt_s   = '0;
          nxt_prior_s = prior_r;
        end
      end
      ST_OWN: begin
        if (keep_s) begin
          nxt_state_s = ST_OWN;
          nxt_grant_s = grant_r;
          nxt_cnt_s   = (cnt_r == CNT_SAT) ? cnt_r : (cnt_r + CNT_ONE);
          nxt_prior_s = prior_r;
        end else begin
          nxt_state_s = ST_GAP;
          nxt_grant_s = '0;
          nxt_cnt_s   = '0;
          nxt_prior_s = prior_r;
        end
      end
      default: begin
        nxt_state_s = ST_IDLE;
        nxt_grant_s = '0;
        nxt_cnt_s   = '0;
        nxt_prior_s = prior_r;
      end
    endcase
  end

  // FSM state and all registered outputs.
  always_ff @(posedge i_bus_clk or negedge i_bus_rstn) begin
    if (!i_bus_rstn) begin
      state_r <= ST_IDLE;
      grant_r <= '0;
      prior_r <= PRIOR_RST;
      cnt_r   <= '0;
      vld_r   <= 1'b0;
      id_r    <= '0;
      err_r   <= 1'b0;
    end else begin
      state_r <= nxt_state_s;
      grant_r <= nxt_grant_s;
      prior_r <= nxt_prior_s;
      cnt_r   <= nxt_cnt_s;
      vld_r   <= |nxt_grant_s;
      id_r    <= nxt_id_s;
      err_r   <= err_r | illegal_s;
    end
  end

  assign o_prior     = prior_r;
  assign o_grant     = grant_r;
  assign o_grant_vld = vld_r;
  assign o_grant_id  = id_r;
  assign o_err       = err_r;

endmodule

// File: tb/tb_arb_grant_ctrl.sv
// ----------------------------------------------------------------------------
// tb_arb_grant_ctrl
//   Bench for arb_grant_ctrl with a behavioural ppa in the loop.
//   The reference model tracks the owner as an integer index, a tenure count
//   and a priority index, and is advanced once per clock from the same inputs.
// ----------------------------------------------------------------------------
module tb_arb_grant_ctrl;

  localparam int N        = 8;
  localparam int MAX_HOLD = 4;
  localparam int ID_W     = 3;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N-1:0]    ppa_g;
  logic            ppa_a;
  logic [N-1:0]    prior;
  logic [N-1:0]    grant;
  logic            grant_vld;
  logic [ID_W-1:0] grant_id;
  logic            err;

  logic            force_en;
  logic [N-1:0]    force_grant;
  logic            force_ag;

  int errors;
  int checks;

  // reference model state
  int m_owner;   // -1 = no owner
  int m_cnt;
  int m_pidx;
  bit m_err;

  wire [20:0] obs = {prior, grant, grant_vld, grant_id, err};

  arb_grant_ctrl #(
    .N         (N),
    .MAX_HOLD  (MAX_HOLD),
    .PRIOR_RST (8'h80),
    .ID_W      (ID_W)
  ) dut (
    .i_bus_clk   (clk),
    .i_bus_rstn  (rst_n),
    .i_req       (req),
    .i_ppa_grant (ppa_g),
    .i_ppa_ag    (ppa_a),
    .o_prior     (prior),
    .o_grant     (grant),
    .o_grant_vld (grant_vld),
    .o_grant_id  (grant_id),
    .o_err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // first requester at or above index p, wrapping
  function automatic logic [7:0] ppa_pick(input logic [7:0] r, input int p);
    logic [7:0] g;
    g = 8'h00;
    for (int k = 7; k >= 0; k--) begin
      if (r[(p + k) % 8]) g = 8'(1 << ((p + k) % 8));
    end
    return g;
  endfunction

  function automatic int oh_idx(input logic [7:0] v);
    int r;
    r = 0;
    for (int i = 0; i < 8; i++) if (v[i]) r = i;
    return r;
  endfunction

  // behavioural ppa fed by the DUT priority, overridable for fault injection
  always_comb begin
    if (force_en) begin
      ppa_g = force_grant;
      ppa_a = force_ag;
    end else begin
      ppa_g = ppa_pick(req, oh_idx(prior));
      ppa_a = |ppa_g;
    end
  end

  function automatic logic [20:0] exp_vec();
    logic [7:0] g;
    logic [2:0] id;
    g  = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
    id = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
    return {8'(1 << m_pidx), g, (m_owner >= 0), id, m_err};
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_cnt   = 0;
    m_pidx  = 7;
    m_err   = 1'b0;
  endtask

  // advance the reference model by one clock using the current inputs
  task automatic model_step();
    logic [7:0] g;
    bit a, legal;
    if (force_en) begin
      g = force_grant;
      a = force_ag;
    end else begin
      g = ppa_pick(req, m_pidx);
      a = (g != 8'h00);
    end
    legal = a && ($countones(g) == 1);
    if (a && !legal) m_err = 1'b1;
    if (m_owner >= 0) begin
      if (req[m_owner] && m_cnt < MAX_HOLD) m_cnt++;
      else begin
        m_owner = -1;
        m_cnt   = 0;
      end
    end else if (legal) begin
      m_owner = oh_idx(g);
      m_cnt   = 1;
      m_pidx  = (m_owner + 1) % N;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic [7:0] r);
    rst_n = 1'b0;
    req   = r;
    force_en = 1'b0;
    model_reset();
    #12;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 8'h48;
    force_en = 1'b0;
    force_grant = 8'h00;
    force_ag = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      #9;
      checks++;
      if (grant !== 8'h00 || prior !== 8'h80 || grant_vld !== 1'b0 || grant_id !== 3'd0 || err !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold t=%0t got prior=%h grant=%h vld=%b id=%0d err=%b required prior=80 grant=00 vld=0 id=0 err=0",
                 $time, prior, grant, grant_vld, grant_id, err);
      end
      #1;
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (obs !== exp_vec() || grant !== 8'h08 || grant_id !== 3'd3 || prior !== 8'h10) begin
      errors++;
      $display("FAIL first_grant got grant=%h id=%0d prior=%h required grant=08 id=3 prior=10", grant, grant_id, prior);
    end
  endtask

  task automatic test_tenure();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs !== exp_vec() || grant !== 8'h08) begin
        errors++;
        $display("FAIL tenure_hold cyc=%0d got=%h required=%h (grant %h vs 08)", i, obs, exp_vec(), grant);
      end
    end
    tick();
    checks++;
    if (obs !== exp_vec() || grant !== 8'h00 || grant_vld !== 1'b0) begin
      errors++;
      $display("FAIL tenure_gap got grant=%h vld=%b required grant=00 vld=0", grant, grant_vld);
    end
    tick();
    checks++;
    if (obs !== exp_vec() || grant !== 8'h40 || grant_id !== 3'd6 || prior !== 8'h80) begin
      errors++;
      $display("FAIL tenure_next got grant=%h id=%0d prior=%h required grant=40 id=6 prior=80", grant, grant_id, prior);
    end
  endtask

  task automatic test_lone_requester();
    req = 8'h01;
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL lone_req cyc=%0d got=%h required=%h", i, obs, exp_vec());
      end
    end
    checks++;
    if (prior !== 8'h02) begin
      errors++;
      $display("FAIL lone_prior got prior=%h required=02", prior);
    end
  endtask

  task automatic test_owner_drop();
    apply_reset(8'h08);
    tick();
    checks++;
    if (obs !== exp_vec() || grant !== 8'h08 || prior !== 8'h10) begin
      errors++;
      $display("FAIL drop_setup got grant=%h prior=%h required grant=08 prior=10", grant, prior);
    end
    req = 8'h41;
    tick();
    checks++;
    if (obs !== exp_vec() || grant !== 8'h00) begin
      errors++;
      $display("FAIL drop_gap got grant=%h required=00", grant);
    end
    tick();
    checks++;
    if (obs !== exp_vec() || grant !== 8'h40 || grant_id !== 3'd6) begin
      errors++;
      $display("FAIL drop_next got grant=%h id=%0d required grant=40 id=6", grant, grant_id);
    end
  endtask

  task automatic test_illegal_grant();
    apply_reset(8'h00);
    tick();
    req = 8'h03;
    force_en = 1'b1;
    force_grant = 8'h03;
    force_ag = 1'b1;
    tick();
    checks++;
    if (obs !== exp_vec() || err !== 1'b1 || grant !== 8'h00) begin
      errors++;
      $display("FAIL illegal_capture got err=%b grant=%h required err=1 grant=00", err, grant);
    end
    force_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (obs !== exp_vec() || err !== 1'b1) begin
        errors++;
        $display("FAIL illegal_sticky cyc=%0d got=%h required=%h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] g;
    apply_reset(8'($urandom));
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) req = 8'($urandom);
      force_en = 1'b0;
      if ($urandom_range(0, 24) == 0) begin
        g = 8'($urandom);
        if ($urandom_range(0, 3) == 0) g = 8'h00;
        else if ($countones(g) <= 1) g = g | 8'h81;
        force_en = 1'b1;
        force_grant = g;
        force_ag = 1'b1;
      end
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc=%0d req=%h got=%h required=%h", i, req, obs, exp_vec());
      end
    end
    force_en = 1'b0;
  endtask

  task automatic test_async_reset();
    apply_reset(8'h08);
    tick();
    tick();
    checks++;
    if (obs !== exp_vec() || grant !== 8'h08) begin
      errors++;
      $display("FAIL areset_setup got grant=%h required=08", grant);
    end
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (grant !== 8'h00 || grant_vld !== 1'b0 || grant_id !== 3'd0 || prior !== 8'h80 || err !== 1'b0) begin
      errors++;
      $display("FAIL areset_immediate got grant=%h vld=%b id=%0d prior=%h err=%b required 00/0/0/80/0",
               grant, grant_vld, grant_id, prior, err);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL areset_hold cyc=%0d got=%h required=%h", i, obs, exp_vec());
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (obs !== exp_vec() || grant !== 8'h08) begin
      errors++;
      $display("FAIL areset_release got grant=%h required=08", grant);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_tenure();
    test_lone_requester();
    test_owner_drop();
    test_illegal_grant();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
